rr_arbiter: RTL
===============

// Module: rr_arbiter
// PURPOSE
//  Round-robin arbiter sharing one resource among N requesters.
//  - Registered one-hot grant, held until the owner releases it or a hold timeout expires.
//  - Selection uses a masked + unmasked pair of priority_encoder instances (highest index wins).
//  - The last owner gets lowest priority on the next arbitration.
//  - Sits in front of any shared datapath (bus port, memory bank) in the cores library.
// PARAMETERS
//  N_REQ         4   number of requesters, >=2
//  MAX_HOLD      8   max consecutive grant cycles per owner; 0 = no timeout
// PORTS
//  clk_i          in   1                  clock, all logic on rising edge
//  rst_n_i        in   1                  reset, asynchronous, active-low
//  req_i          in   N_REQ              request per requester, level
//  done_i         in   1                  release strobe from current owner
//  gnt_o          out  N_REQ              one-hot grant, registered
//  gnt_idx_o      out  $clog2(N_REQ)      binary index of owner, registered
//  gnt_valid_o    out  1                  grant active (== |gnt_o)
//  preempt_o      out  1                  1-cycle pulse: owner evicted by timeout
// BEHAVIOUR
//  Reset (async assert, sync deassert assumed upstream):
//  - gnt_o=0, gnt_idx_o=0, gnt_valid_o=0, preempt_o=0.
//  - state=IDLE, hold_cnt=0, mask=all-ones.
//  Arbitration (combinational, same cycle):
//  - cand_masked = req_i & mask.
//  - Winner = highest set bit of cand_masked if nonzero, else highest set bit of req_i.
//  - After a grant to k: mask = (1<<k)-1, i.e. only indices below k keep priority.
//    Index 0 owner -> mask=0 -> falls back to unmasked (wrap).
//  FSM: IDLE, BUSY.
//  IDLE:
//  - |req_i=1 -> register winner into gnt_o/gnt_idx_o at next edge; ->BUSY; hold_cnt=0.
//  - Latency req->gnt = 1 cycle.
//  BUSY: release condition rel = done_i | ~req_i[gnt_idx_o] | timeout.
//  - timeout = (MAX_HOLD!=0) & (hold_cnt==MAX_HOLD-1).
//  - rel=0: grant held, hold_cnt++ (saturates; never wraps).
//  - rel=1: mask updated from current owner; new winner from req_i AND mask at the same edge.
//    No bubble: back-to-back grant.
//    Sole remaining requester == old owner -> re-granted, hold_cnt=0.
//    No requests -> gnt_o=0, ->IDLE.
//  - preempt_o=1 for one cycle (registered) only when timeout caused release and done_i=0.
//  Boundaries:
//  - done_i in IDLE is ignored.
//  - done_i and timeout in the same cycle -> treated as done (preempt_o=0).
//  - Owner deasserts req with done_i=0 -> normal release, no preempt.
//  - req_i changes of non-owners never alter an active grant.
//  - gnt_o always one-hot or zero; gnt_idx_o holds its last value while gnt_valid_o=0.
//  - Reset mid-grant: outputs drop to reset values immediately, mask returns to all-ones.
//  Widths: hold_cnt $clog2(MAX_HOLD+1) bits (min 1); idx $clog2(N_REQ).
// STRUCTURE
//  rr_arbiter_package:
//  - typedef enum logic {IDLE, BUSY} rr_state_t.
//  - Function onehot(idx,N) and low_mask(idx,N) returning (1<<idx)-1.
//  Sub-module: two priority_encoder instances (CORE_VERSION=V2_GENERIC, DATA_WIDTH=N_REQ):
//  - one fed req_i & mask, one fed req_i; their valid_o selects the winner.
//  - Grant/mask/hold_cnt/state registers in one always_ff; next-state logic in always_comb.
// TESTING (N_REQ=4, MAX_HOLD=8)
//  1. Reset, req_i=4'b0000 -> gnt_valid_o=0; assert/deassert rst_n_i mid-grant -> gnt_o=0 same cycle.
//  2. req_i=4'b1010 held, done_i pulse each 2 cycles:
//     grants alternate 3,1,3,1; each new grant on the edge after done_i, no bubble.
//  3. req_i=4'b1111 held, done_i every cycle -> gnt_idx_o sequence 3,2,1,0,3 (wrap).
//  4. req_i=4'b0100 only, done_i=0 -> gnt_o=4'b0100 for 8 cycles, preempt_o pulse, then re-granted to 2.
//  5. Owner 3 drops req_i[3] while req_i[0]=1 -> next edge gnt_o=4'b0001, preempt_o=0.
//  6. done_i coincident with timeout and req_i=4'b0000 -> IDLE next edge, gnt_o=0, preempt_o=0.
//  All tests: assert $onehot0(gnt_o) and gnt_valid_o==|gnt_o every cycle.

Source files
------------

// File: rtl/rr_arbiter_pkg.sv
// Shared types and helpers for the round-robin arbiter.
//   rr_state_t  : arbiter FSM state (IDLE, BUSY)
//   pe_core_t   : priority encoder implementation selector
//   onehot()    : one-hot vector with bit idx set, limited to n bits
//   low_mask()  : (1<<idx)-1 limited to n bits; indices below idx keep priority
package rr_arbiter_pkg;

  typedef enum logic {IDLE, BUSY} rr_state_t;

  typedef enum logic {V1_LEGACY, V2_GENERIC} pe_core_t;

  // Upper bound on requester count supported by the helper functions.
  localparam int MAX_REQ = 32;

  function automatic logic [MAX_REQ-1:0] onehot(input int idx, input int n);
    logic [MAX_REQ-1:0] r;
    r = '0;
    for (int i = 0; i < MAX_REQ; i++) begin
      if ((i < n) && (i == idx)) r[i] = 1'b1;
    end
    return r;
  endfunction

  function automatic logic [MAX_REQ-1:0] low_mask(input int idx, input int n);
    logic [MAX_REQ-1:0] r;
    r = '0;
    for (int i = 0; i < MAX_REQ; i++) begin
      if ((i < n) && (i < idx)) r[i] = 1'b1;
    end
    return r;
  endfunction

endpackage

// File: rtl/rr_arbiter_priority_encoder.sv
// Priority encoder: highest set bit of data_i wins.
//   data_i  in  DATA_WIDTH  candidate vector
//   idx_o   out IDX_W       binary index of highest set bit (0 when none)
//   valid_o out 1           at least one bit of data_i is set
module priority_encoder
  import rr_arbiter_pkg::*;
#(
  parameter pe_core_t CORE_VERSION = V2_GENERIC,
  parameter int       DATA_WIDTH   = 4,
  localparam int      IDX_W        = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1
) (
  input  logic [DATA_WIDTH-1:0] data_i,
  output logic [IDX_W-1:0]      idx_o,
  output logic                  valid_o
);

  if (CORE_VERSION == V2_GENERIC) begin : g_v2
    // Ascending scan: the last hit (highest index) overwrites earlier ones.
    always_comb begin
      idx_o   = '0;
      valid_o = 1'b0;
      for (int i = 0; i < DATA_WIDTH; i++) begin
        if (data_i[i]) begin
          idx_o   = IDX_W'(i);
          valid_o = 1'b1;
        end
      end
    end
  end else begin : g_v1
    // Descending scan with a found flag: first hit from the top sticks.
    always_comb begin
      idx_o   = '0;
      valid_o = 1'b0;
      for (int i = DATA_WIDTH - 1; i >= 0; i--) begin
        if (data_i[i] && !valid_o) begin
          idx_o   = IDX_W'(i);
          valid_o = 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/rr_arbiter.sv
// Round-robin arbiter sharing one resource among N_REQ requesters.
//   clk_i        in  1      clock, rising edge
//   rst_n_i      in  1      asynchronous active-low reset
//   req_i        in  N_REQ  level request per requester
//   done_i       in  1      release strobe from current owner
//   gnt_o        out N_REQ  registered one-hot grant
//   gnt_idx_o    out IDX_W  registered binary index of owner
//   gnt_valid_o  out 1      grant active (|gnt_o)
//   preempt_o    out 1      one-cycle pulse when owner evicted by timeout
module rr_arbiter
  import rr_arbiter_pkg::*;
#(
  parameter int  N_REQ    = 4,
  parameter int  MAX_HOLD = 8,
  localparam int IDX_W    = $clog2(N_REQ),
  localparam int HOLD_W   = (MAX_HOLD > 0) ? $clog2(MAX_HOLD + 1) : 1
) (
  input  logic             clk_i,
  input  logic             rst_n_i,
  input  logic [N_REQ-1:0] req_i,
  input  logic             done_i,
  output logic [N_REQ-1:0] gnt_o,
  output logic [IDX_W-1:0] gnt_idx_o,
  output logic             gnt_valid_o,
  output logic             preempt_o
);

  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'((MAX_HOLD > 0) ? MAX_HOLD - 1 : 0);

  rr_state_t        r_state,    w_state_next;
  logic [N_REQ-1:0] r_gnt,      w_gnt_next;
  logic [IDX_W-1:0] r_gnt_idx,  w_gnt_idx_next;
  logic [N_REQ-1:0] r_mask,     w_mask_next;
  logic [HOLD_W-1:0] r_hold_cnt, w_hold_cnt_next;
  logic             r_preempt,  w_preempt_next;

  logic [N_REQ-1:0] w_cand_masked;
  logic [IDX_W-1:0] w_idx_masked, w_idx_unmasked, w_win_idx;
  logic             w_valid_masked, w_valid_unmasked;
  logic             w_timeout, w_owner_req, w_rel;

  // r_mask always reflects the most recent owner, so the same candidate
  // vector serves both a fresh arbitration from IDLE and a release in BUSY.
  assign w_cand_masked = req_i & r_mask;

  priority_encoder #(
    .CORE_VERSION(V2_GENERIC),
    .DATA_WIDTH  (N_REQ)
  ) u_pe_masked (
    .data_i (w_cand_masked),
    .idx_o  (w_idx_masked),
    .valid_o(w_valid_masked)
  );

  priority_encoder #(
    .CORE_VERSION(V2_GENERIC),
    .DATA_WIDTH  (N_REQ)
  ) u_pe_unmasked (
    .data_i (req_i),
    .idx_o  (w_idx_unmasked),
    .valid_o(w_valid_unmasked)
  );

  // Empty masked set means everyone of lower index is idle: wrap to the top.
  assign w_win_idx   = w_valid_masked ? w_idx_masked : w_idx_unmasked;
  assign w_timeout   = (MAX_HOLD != 0) && (r_hold_cnt == HOLD_LAST);
  assign w_owner_req = req_i[r_gnt_idx];
  assign w_rel       = done_i | ~w_owner_req | w_timeout;

  always_comb begin
    w_state_next    = r_state;
    w_gnt_next      = r_gnt;
    w_gnt_idx_next  = r_gnt_idx;
    w_mask_next     = r_mask;
    w_hold_cnt_next = r_hold_cnt;
    w_preempt_next  = 1'b0;

    case (r_state)
      IDLE: begin
        if (w_valid_unmasked) begin
          w_gnt_next      = N_REQ'(onehot(int'(w_win_idx), N_REQ));
          w_gnt_idx_next  = w_win_idx;
          w_mask_next     = N_REQ'(low_mask(int'(w_win_idx), N_REQ));
          w_hold_cnt_next = '0;
          w_state_next    = BUSY;
        end
      end
      BUSY: begin
        if (w_rel) begin
          // Eviction only counts when the owner still wanted the resource
          // and did not release it itself in the same cycle.
          w_preempt_next  = w_timeout & ~done_i & w_owner_req;
          w_hold_cnt_next = '0;
          if (w_valid_unmasked) begin
            w_gnt_next     = N_REQ'(onehot(int'(w_win_idx), N_REQ));
            w_gnt_idx_next = w_win_idx;
            w_mask_next    = N_REQ'(low_mask(int'(w_win_idx), N_REQ));
          end else begin
            w_gnt_next   = '0;
            w_state_next = IDLE;
          end
        end else if (r_hold_cnt != '1) begin
          w_hold_cnt_next = r_hold_cnt + 1'b1;
        end
      end
      default: w_state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_state    <= IDLE;
      r_gnt      <= '0;
      r_gnt_idx  <= '0;
      r_mask     <= '1;
      r_hold_cnt <= '0;
      r_preempt  <= 1'b0;
    end else begin
      r_state    <= w_state_next;
      r_gnt      <= w_gnt_next;
      r_gnt_idx  <= w_gnt_idx_next;
      r_mask     <= w_mask_next;
      r_hold_cnt <= w_hold_cnt_next;
      r_preempt  <= w_preempt_next;
    end
  end

  assign gnt_o       = r_gnt;
  assign gnt_idx_o   = r_gnt_idx;
  assign gnt_valid_o = |r_gnt;
  assign preempt_o   = r_preempt;

endmodule
